// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: default widths and the
// write-sequencer state encoding.
package uart_tx_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the UART transmit FIFO: synchronous write,
// asynchronous read, contents are not reset.
module uart_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read is combinational so the pop can register the head byte directly.
    assign rd_data_o = r_mem[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus write sequencer that feeds UartTx through the level
// write/busy handshake so queued bytes leave back-to-back.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  clear_overflow_i,
    output logic                  idle_o,
    output logic                  tx_write_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    input  logic                  tx_busy_i
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_tx_write;
    logic [DATA_WIDTH-1:0] r_tx_data;
    tx_state_e             r_state;

    tx_state_e             w_state_next;
    logic                  w_tx_write_next;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_overflow_set;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == IDLE) && !w_empty;
    // A simultaneous pop frees a slot, so a push at full is still taken.
    assign w_push_ok      = push_i && (!w_full || w_pop);
    assign w_overflow_set = push_i && w_full && !w_pop;

    uart_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clock_i   (clock_i),
        .wr_en_i   (w_push_ok),
        .wr_addr_i (r_wr_ptr),
        .wr_data_i (data_i),
        .rd_addr_i (r_rd_ptr),
        .rd_data_o (w_rd_data)
    );

    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_tx_write_next = r_tx_write;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_next    = LOAD;
                    w_tx_write_next = 1'b1;
                end
            end
            LOAD: begin
                if (tx_busy_i) begin
                    w_state_next    = WAIT_BUSY;
                    w_tx_write_next = 1'b0;
                end
            end
            WAIT_BUSY: begin
                if (!tx_busy_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_tx_write_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_write <= 1'b0;
            r_tx_data  <= '0;
            r_state    <= IDLE;
        end else begin
            r_count    <= w_count_next;
            r_state    <= w_state_next;
            r_tx_write <= w_tx_write_next;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= w_rd_data;
            end
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign full_o     = w_full;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign tx_write_o = r_tx_write;
    assign tx_data_o  = r_tx_data;
    assign idle_o     = w_empty && (r_state == IDLE) && !tx_busy_i;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a UartTx stand-in whose busy rises
// one cycle after write and lasts 20 cycles.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] din = 8'h00;
    logic       clr = 1'b0;
    logic       busy = 1'b0;
    logic       full;
    logic [4:0] cnt;
    logic       ovf;
    logic       idle;
    logic       txw;
    logic [7:0] txd;

    int n_vec = 0;
    int n_err = 0;

    bit         model_en = 1'b1;
    int         rem = 0;
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    int         n_wr_edges = 0;
    int         n_data_viol = 0;
    logic       rst_q = 1'b1;
    logic       last_w = 1'b0;
    logic       last_b = 1'b0;
    logic [7:0] last_d = 8'h00;

    uart_tx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH_LOG2 (4)
    ) dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .push_i           (push),
        .data_i           (din),
        .full_o           (full),
        .count_o          (cnt),
        .overflow_o       (ovf),
        .clear_overflow_i (clr),
        .idle_o           (idle),
        .tx_write_o       (txw),
        .tx_data_o        (txd),
        .tx_busy_i        (busy)
    );

    always #5 clk = ~clk;

    // UartTx stand-in: accepts a byte when write is seen while not busy.
    always @(posedge clk) begin
        rst_q <= rst;
        if (model_en && txw && !busy && rem == 0) begin
            busy <= 1'b1;
            rem  <= 20;
            cap.push_back(txd);
        end else if (rem > 1) begin
            rem <= rem - 1;
        end else if (rem == 1) begin
            rem  <= 0;
            busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_q) begin
            if (txw && !last_w) n_wr_edges++;
            if (txd !== last_d && (last_w || last_b)) n_data_viol++;
        end
        last_w = txw;
        last_b = busy;
        last_d = txd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        push = 1'b1;
        din  = b;
        step();
    endtask

    task automatic wait_busy(input logic lvl, input int lim, input string tag);
        int k = 0;
        while (busy !== lvl && k < lim) begin
            step();
            k++;
        end
        check(tag, {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (!idle && k < 1200) begin
            step();
            k++;
        end
        check({tag, "_idle"}, {31'd0, idle}, 32'd1);
        check({tag, "_nbytes"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, cap[i]}, {24'd0, exp_q[i]});
        end
        check({tag, "_writes"}, n_wr_edges, exp_q.size());
        cap.delete();
        exp_q.delete();
        n_wr_edges = 0;
    endtask

    initial begin
        // Test 1: reset values and single-byte latency
        step(2);
        check("rst_count", {27'd0, cnt}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_write", {31'd0, txw}, 32'd0);
        check("rst_data", {24'd0, txd}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        rst = 1'b0;
        step();
        push_byte(8'h55);
        push = 1'b0;
        check("t1_count_n1", {27'd0, cnt}, 32'd1);
        check("t1_write_n1", {31'd0, txw}, 32'd0);
        step();
        check("t1_write_n2", {31'd0, txw}, 32'd1);
        check("t1_data_n2", {24'd0, txd}, 32'h55);
        check("t1_count_n2", {27'd0, cnt}, 32'd0);
        check("t1_idle_n2", {31'd0, idle}, 32'd0);
        step();
        check("t1_busy_n3", {31'd0, busy}, 32'd1);
        check("t1_write_n3", {31'd0, txw}, 32'd1);
        step();
        check("t1_write_n4", {31'd0, txw}, 32'd0);
        exp_q.push_back(8'h55);
        drain("t1");

        // Test 2: fill to 16 behind a byte in flight, drain in order
        push_byte(8'hF0);
        push = 1'b0;
        exp_q.push_back(8'hF0);
        step();
        for (int i = 1; i <= 16; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        push = 1'b0;
        check("t2_count", {27'd0, cnt}, 32'd16);
        check("t2_full", {31'd0, full}, 32'd1);
        drain("t2");

        // Test 3/6: busy never rises, fill, overflow and clear
        model_en = 1'b0;
        push_byte(8'hB0);
        for (int i = 0; i < 16; i++) push_byte(8'(8'hC0 + i));
        push = 1'b0;
        check("t3_count", {27'd0, cnt}, 32'd16);
        check("t3_full", {31'd0, full}, 32'd1);
        check("t3_ovf0", {31'd0, ovf}, 32'd0);
        push_byte(8'hAA);
        push = 1'b0;
        check("t3_ovf_set", {31'd0, ovf}, 32'd1);
        check("t3_count_ovf", {27'd0, cnt}, 32'd16);
        clr = 1'b1;
        push_byte(8'hAB);
        push = 1'b0;
        check("t3_set_wins", {31'd0, ovf}, 32'd1);
        step();
        clr = 1'b0;
        check("t3_ovf_clr", {31'd0, ovf}, 32'd0);
        step(30);
        check("t6_write_held", {31'd0, txw}, 32'd1);
        check("t6_data_held", {24'd0, txd}, 32'hB0);
        check("t6_idle", {31'd0, idle}, 32'd0);
        check("t6_count", {27'd0, cnt}, 32'd16);

        // Test 4: push on the IDLE pop cycle at count 16
        model_en = 1'b1;
        wait_busy(1'b1, 5, "t4_busy_rise");
        wait_busy(1'b0, 40, "t4_busy_fall");
        step();
        push_byte(8'hDD);
        push = 1'b0;
        check("t4_count", {27'd0, cnt}, 32'd16);
        check("t4_ovf", {31'd0, ovf}, 32'd0);
        check("t4_write", {31'd0, txw}, 32'd1);
        check("t4_data", {24'd0, txd}, 32'hC0);
        exp_q.push_back(8'hB0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'hC0 + i));
        exp_q.push_back(8'hDD);
        drain("t4");

        // Test 5: reset during WAIT_BUSY with 5 bytes queued
        for (int i = 0; i < 6; i++) push_byte(8'(8'hE0 + i));
        push = 1'b0;
        wait_busy(1'b1, 10, "t5_busy_rise");
        step(2);
        check("t5_count_pre", {27'd0, cnt}, 32'd5);
        check("t5_write_pre", {31'd0, txw}, 32'd0);
        rst = 1'b1;
        step();
        check("t5_count_rst", {27'd0, cnt}, 32'd0);
        check("t5_write_rst", {31'd0, txw}, 32'd0);
        check("t5_data_rst", {24'd0, txd}, 32'd0);
        rst = 1'b0;
        check("t5_idle_busy", {31'd0, idle}, 32'd0);
        wait_busy(1'b0, 40, "t5_busy_fall");
        check("t5_idle_after", {31'd0, idle}, 32'd1);
        step(40);
        check("t5_count_end", {27'd0, cnt}, 32'd0);
        exp_q.push_back(8'hE0);
        drain("t5");

        check("data_stable", n_data_viol, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
